calc2_req_issuer: RTL and testbench

Per-port request issuer and in-order response collector placed directly upstream/downstream of one CalcII port.
- Accepts whole operations (cmd + two operands) on a valid/ready interface.
- Assigns tags round-robin and drives the two-cycle CalcII request protocol (req_cmd_in/req_data_in/req_tag_in).
- Captures out_resp/out_data/out_tag, which may complete out of order.
- Returns results in issue order; one instance per port (1..4) replaces per-port stimulus logic.

---
 rtl/calc2_pkg.sv | 42 ++++
 rtl/calc2_rsp_rob.sv | 123 ++++++++++++
 rtl/calc2_req_issuer.sv | 137 +++++++++++++
 tb/tb_calc2_req_issuer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// ============================================================================
// calc2_pkg : shared types and constants for the CalcII per-port issuer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package calc2_pkg;

  typedef logic [1:0]  tag_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  cmd_t;
  typedef logic [1:0]  resp_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_ADD = 4'd1;
  localparam cmd_t CMD_SUB = 4'd2;
  localparam cmd_t CMD_SHL = 4'd5;
  localparam cmd_t CMD_SHR = 4'd6;

  localparam resp_t RESP_NONE = 2'd0;
  localparam resp_t RESP_OK   = 2'd1;
  localparam resp_t RESP_OVF  = 2'd2;
  localparam resp_t RESP_INV  = 2'd3;

  localparam int NUM_SLOTS = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_OPND2 = 2'd2;

  typedef struct packed {
    logic  pending;
    logic  done;
    logic  timeout;
    cmd_t  cmd;
    resp_t resp;
    data_t data;
  } slot_t;

endpackage

`default_nettype wire

// File: rtl/calc2_rsp_rob.sv
// ============================================================================
// calc2_rsp_rob : 4-slot reorder buffer with capture, in-order retire, watchdog
// Revision      : 1.0
// ============================================================================
`default_nettype none

module calc2_rsp_rob
  import calc2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       c_clk,
  input  logic       reset,
  input  logic       alloc_valid,
  input  tag_t       alloc_tag,
  input  cmd_t       alloc_cmd,
  input  logic       opnd2_valid,
  input  tag_t       opnd2_tag,
  input  resp_t      out_resp,
  input  data_t      out_data,
  input  tag_t       out_tag,
  input  logic       rsp_ready,
  output logic       rsp_valid,
  output resp_t      rsp_resp,
  output data_t      rsp_data,
  output cmd_t       rsp_cmd,
  output tag_t       rsp_tag,
  output logic       rsp_timeout,
  output logic [2:0] outstanding,
  output logic       err_unexp_tag
);

  localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT_CYCLES - 1);

  slot_t                slot_q [NUM_SLOTS];
  slot_t                slot_d [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] armed_q, armed_d;
  tag_t                 head_q, head_d;
  logic [2:0]           count_q, count_d;
  logic [9:0]           wd_q, wd_d;
  logic                 err_q, err_d;

  slot_t head_slot;
  logic  retire, cap_ok, wd_run, wd_fire;

  always_comb begin
    head_slot = slot_q[head_q];
    retire    = head_slot.done && rsp_ready;
    cap_ok    = (out_resp != RESP_NONE) && slot_q[out_tag].pending && !slot_q[out_tag].done;
    err_d     = (out_resp != RESP_NONE) && !cap_ok;
    // The head only ages once its second request beat is on the bus.
    wd_run    = (count_q != 3'd0) && head_slot.pending && !head_slot.done &&
                (armed_q[head_q] || (opnd2_valid && (opnd2_tag == head_q)));
    wd_fire   = wd_run && (wd_q == WD_LIMIT) && !(cap_ok && (out_tag == head_q));

    slot_d  = slot_q;
    armed_d = armed_q;
    head_d  = head_q;
    wd_d    = wd_run ? (wd_q + 10'd1) : 10'd0;

    if (retire) begin
      slot_d[head_q]  = '0;
      armed_d[head_q] = 1'b0;
      head_d          = head_q + 2'd1;
      wd_d            = 10'd0;
    end
    if (alloc_valid) begin
      slot_d[alloc_tag]         = '0;
      slot_d[alloc_tag].pending = 1'b1;
      slot_d[alloc_tag].cmd     = alloc_cmd;
    end
    if (opnd2_valid) begin
      armed_d[opnd2_tag] = 1'b1;
    end
    if (cap_ok) begin
      slot_d[out_tag].done = 1'b1;
      slot_d[out_tag].resp = out_resp;
      slot_d[out_tag].data = out_data;
    end
    if (wd_fire) begin
      slot_d[head_q].done    = 1'b1;
      slot_d[head_q].timeout = 1'b1;
      slot_d[head_q].resp    = RESP_NONE;
      slot_d[head_q].data    = '0;
    end

    count_d = count_q + 3'(alloc_valid) - 3'(retire);
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= '0;
      end
      armed_q <= '0;
      head_q  <= '0;
      count_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      armed_q <= armed_d;
      head_q  <= head_d;
      count_q <= count_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid     = head_slot.done;
  assign rsp_resp      = head_slot.resp;
  assign rsp_data      = head_slot.data;
  assign rsp_cmd       = head_slot.cmd;
  assign rsp_tag       = head_q;
  assign rsp_timeout   = head_slot.timeout;
  assign outstanding   = count_q;
  assign err_unexp_tag = err_q;

endmodule

`default_nettype wire

// File: rtl/calc2_req_issuer.sv
// ============================================================================
// calc2_req_issuer : CalcII per-port op issuer with in-order result return
// Revision         : 1.0
// ============================================================================
`default_nettype none

module calc2_req_issuer
  import calc2_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_cmd,
  input  logic [31:0] op_data1,
  input  logic [31:0] op_data2,
  output logic [3:0]  req_cmd_in,
  output logic [31:0] req_data_in,
  output logic [1:0]  req_tag_in,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  input  logic [1:0]  out_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_cmd,
  output logic [1:0]  rsp_tag,
  output logic        rsp_timeout,
  output logic [2:0]  outstanding,
  output logic        err_unexp_tag
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  logic [1:0] state_q, state_d;
  tag_t       next_tag_q, next_tag_d;
  tag_t       cur_tag_q, cur_tag_d;
  data_t      op2_q, op2_d;
  cmd_t       req_cmd_q, req_cmd_d;
  data_t      req_data_q, req_data_d;
  tag_t       req_tag_q, req_tag_d;
  logic       rdy_en_q;
  logic       hs;

  // rdy_en_q holds op_ready low until the first edge after reset release.
  assign op_ready = rdy_en_q && (state_q != ST_CMD) && (outstanding < MAX_CNT);
  assign hs       = op_valid && op_ready;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      next_tag_q <= '0;
      cur_tag_q  <= '0;
      op2_q      <= '0;
      req_cmd_q  <= CMD_NOP;
      req_data_q <= '0;
      req_tag_q  <= '0;
      rdy_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_tag_q <= next_tag_d;
      cur_tag_q  <= cur_tag_d;
      op2_q      <= op2_d;
      req_cmd_q  <= req_cmd_d;
      req_data_q <= req_data_d;
      req_tag_q  <= req_tag_d;
      rdy_en_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    next_tag_d = next_tag_q;
    cur_tag_d  = cur_tag_q;
    op2_d      = op2_q;
    case (state_q)
      ST_CMD:  state_d = ST_OPND2;
      default: state_d = hs ? ST_CMD : ST_IDLE;
    endcase
    if (hs) begin
      next_tag_d = next_tag_q + 2'd1;
      cur_tag_d  = next_tag_q;
      op2_d      = op_data2;
    end
  end

  // Request beats are computed from the next state so the bus is registered.
  always_comb begin
    req_cmd_d  = CMD_NOP;
    req_data_d = '0;
    req_tag_d  = '0;
    case (state_d)
      ST_CMD: begin
        req_cmd_d  = op_cmd;
        req_data_d = op_data1;
        req_tag_d  = next_tag_q;
      end
      ST_OPND2: req_data_d = op2_q;
      default: ;
    endcase
  end

  assign req_cmd_in  = req_cmd_q;
  assign req_data_in = req_data_q;
  assign req_tag_in  = req_tag_q;

  calc2_rsp_rob #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rob (
    .c_clk        (c_clk),
    .reset        (reset),
    .alloc_valid  (hs),
    .alloc_tag    (next_tag_q),
    .alloc_cmd    (op_cmd),
    .opnd2_valid  (state_q == ST_OPND2),
    .opnd2_tag    (cur_tag_q),
    .out_resp     (out_resp),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .rsp_ready    (rsp_ready),
    .rsp_valid    (rsp_valid),
    .rsp_resp     (rsp_resp),
    .rsp_data     (rsp_data),
    .rsp_cmd      (rsp_cmd),
    .rsp_tag      (rsp_tag),
    .rsp_timeout  (rsp_timeout),
    .outstanding  (outstanding),
    .err_unexp_tag(err_unexp_tag)
  );

endmodule

`default_nettype wire

// File: tb/tb_calc2_req_issuer.sv
// ============================================================================
// tb_calc2_req_issuer : directed + random bench with an in-bench CalcII model
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_calc2_req_issuer;
  import calc2_pkg::*;

  localparam int MAXO = 4;
  localparam int TO   = 16;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0, op_ready;
  logic [3:0]  op_cmd = '0;
  logic [31:0] op_data1 = '0, op_data2 = '0;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp = '0;
  logic [31:0] out_data = '0;
  logic [1:0]  out_tag = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_cmd;
  logic [1:0]  rsp_tag;
  logic        rsp_timeout;
  logic [2:0]  outstanding;
  logic        err_unexp_tag;

  always #5 c_clk = ~c_clk;

  calc2_req_issuer #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)) dut (
    .c_clk(c_clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
    .op_data1(op_data1), .op_data2(op_data2),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_data(rsp_data), .rsp_cmd(rsp_cmd), .rsp_tag(rsp_tag),
    .rsp_timeout(rsp_timeout), .outstanding(outstanding), .err_unexp_tag(err_unexp_tag)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string t, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", t, got, exp, cyc);
    end
  endtask

  // Reference: issue-ordered queue of tags plus per-tag result records.
  typedef struct {
    int          tag;
    int          due;
    logic [1:0]  resp;
    logic [31:0] data;
  } fl_t;

  fl_t         infl[$];
  int          ord[$];
  int          dly_q[$];
  bit          m_pend[4], m_done[4], m_to[4];
  logic [3:0]  m_cmd[4];
  logic [1:0]  m_resp[4];
  logic [31:0] m_data[4];
  int          m_o2[4];
  int          head_since, next_tag, n_issued, dly_mode;
  bit          ready_en, hs_prev, cmd_prev, err_exp, stray_en;
  logic [1:0]  stray_tag;
  logic [3:0]  cur_cmd;
  logic [31:0] cur_d1, cur_d2;
  int          cur_tag;

  function automatic logic [31:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      CMD_ADD: return a + b;
      CMD_SUB: return a - b;
      CMD_SHL: return a << b[4:0];
      CMD_SHR: return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    ord.delete();
    infl.delete();
    dly_q.delete();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_done[i] = 0; m_to[i] = 0;
      m_cmd[i] = '0; m_resp[i] = '0; m_data[i] = '0; m_o2[i] = 0;
    end
    next_tag = 0; ready_en = 0; hs_prev = 0; cmd_prev = 0;
    err_exp = 0; stray_en = 0; head_since = 0;
  endtask

  // One clock cycle: drive the responder, check every output, advance the model.
  task automatic tick();
    bit          drv, hs, ret, eo, ev;
    int          h, d, st;
    logic [3:0]  ec;
    logic [31:0] ed;
    logic [1:0]  et, rr;
    drv = 0;
    out_resp = '0; out_tag = '0; out_data = '0;
    if (stray_en) begin
      out_resp = RESP_OK; out_tag = stray_tag; out_data = 32'hdead_beef;
      drv = 1; stray_en = 0;
    end else begin
      for (int i = 0; i < infl.size(); i++) begin
        if (infl[i].due <= cyc) begin
          out_resp = infl[i].resp; out_tag = 2'(infl[i].tag); out_data = infl[i].data;
          drv = 1;
          infl.delete(i);
          break;
        end
      end
    end
    #1;
    eo = ready_en && !hs_prev && (ord.size() < MAXO);
    chk("op_ready", op_ready, eo);
    if (hs_prev) begin
      ec = cur_cmd; ed = cur_d1; et = 2'(cur_tag);
    end else if (cmd_prev) begin
      ec = '0; ed = cur_d2; et = '0;
    end else begin
      ec = '0; ed = '0; et = '0;
    end
    chk("req_cmd", req_cmd_in, ec);
    chk("req_data", req_data_in, ed);
    chk("req_tag", req_tag_in, et);
    chk("outstanding", outstanding, ord.size());
    chk("err_unexp", err_unexp_tag, err_exp);
    ev = (ord.size() > 0) && m_done[ord[0]];
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      h = ord[0];
      chk("rsp_tag", rsp_tag, h);
      chk("rsp_cmd", rsp_cmd, m_cmd[h]);
      chk("rsp_resp", rsp_resp, m_resp[h]);
      chk("rsp_data", rsp_data, m_data[h]);
      chk("rsp_timeout", rsp_timeout, m_to[h]);
    end
    hs  = op_valid && eo;
    ret = ev && rsp_ready;
    err_exp = 0;
    if (drv) begin
      if (m_pend[out_tag] && !m_done[out_tag]) begin
        m_done[out_tag] = 1; m_resp[out_tag] = out_resp; m_data[out_tag] = out_data;
      end else begin
        err_exp = 1;
      end
    end
    if (ret) begin
      h = ord.pop_front();
      m_pend[h] = 0; m_done[h] = 0; m_to[h] = 0;
      m_cmd[h] = '0; m_resp[h] = '0; m_data[h] = '0;
      head_since = cyc + 1;
    end
    if (hs) begin
      m_pend[next_tag] = 1; m_cmd[next_tag] = op_cmd; m_o2[next_tag] = cyc + 2;
      if (ord.size() == 0) head_since = cyc + 1;
      ord.push_back(next_tag);
      if (dly_mode != 2) begin
        if (dly_mode == 0) begin
          d  = int'($urandom_range(0, 10));
          rr = 2'($urandom_range(1, 3));
        end else begin
          d  = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
          rr = RESP_OK;
        end
        infl.push_back('{tag: next_tag, due: cyc + 2 + d, resp: rr, data: alu(op_cmd, op_data1, op_data2)});
      end
      cur_cmd = op_cmd; cur_d1 = op_data1; cur_d2 = op_data2; cur_tag = next_tag;
      next_tag = (next_tag + 1) % 4;
      n_issued++;
    end
    cmd_prev = hs_prev;
    hs_prev  = hs;
    ready_en = 1;
    cyc++;
    if (ord.size() > 0) begin
      h  = ord[0];
      st = (m_o2[h] > head_since) ? m_o2[h] : head_since;
      if (!m_done[h] && (cyc == st + TO)) begin
        m_done[h] = 1; m_to[h] = 1; m_resp[h] = '0; m_data[h] = '0;
      end
    end
    @(posedge c_clk);
    #1;
  endtask

  task automatic drain();
    op_valid  = 0;
    rsp_ready = 1;
    for (int k = 0; k < 80; k++) begin
      if (ord.size() == 0 && infl.size() == 0 && !hs_prev && !cmd_prev) break;
      tick();
    end
    chk("drain_empty", outstanding, 0);
  endtask

  task automatic issue_n(input int n);
    int start;
    start    = n_issued;
    op_valid = 1;
    for (int k = 0; k < 60 && (n_issued - start) < n; k++) begin
      op_cmd   = 4'($urandom_range(0, 15));
      op_data1 = $urandom;
      op_data2 = $urandom;
      tick();
    end
    op_valid = 0;
    chk("issue_count", n_issued - start, n);
  endtask

  initial begin
    n_issued = 0;
    dly_mode = 0;
    model_reset();
    repeat (3) @(posedge c_clk);
    #1;
    chk("rst_op_ready", op_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_req_cmd", req_cmd_in, 0);
    chk("rst_err", err_unexp_tag, 0);
    reset = 1;
    tick();

    // Single ADD 5+3, answered in its OPND2 cycle.
    dly_mode = 1; dly_q = '{0};
    rsp_ready = 1; op_valid = 1; op_cmd = CMD_ADD; op_data1 = 32'd5; op_data2 = 32'd3;
    tick();
    op_valid = 0;
    repeat (6) tick();

    // Four ops, responses returning out of order.
    dly_q = '{8, 8, 3, 3};
    issue_n(4);
    drain();

    // Four ops held by rsp_ready=0, op_valid kept high against a full window.
    rsp_ready = 0;
    dly_q = '{0, 0, 0, 0};
    issue_n(4);
    op_valid = 1;
    repeat (10) tick();
    rsp_ready = 1;
    repeat (8) tick();
    drain();

    // Stray response with nothing pending.
    stray_en = 1; stray_tag = 2'd3;
    repeat (3) tick();

    // Watchdog: no response, then a late response on the timed-out tag.
    dly_mode = 2; rsp_ready = 0;
    issue_n(1);
    repeat (22) tick();
    stray_en = 1; stray_tag = 2'(cur_tag);
    repeat (2) tick();
    dly_mode = 0;
    drain();

    // Asynchronous reset landing in a CMD cycle.
    op_valid = 1; op_cmd = CMD_SHL; op_data1 = 32'h1; op_data2 = 32'h4;
    tick();
    op_valid = 0;
    chk("pre_rst_cmd", req_cmd_in, CMD_SHL);
    reset = 0;
    #1;
    chk("async_rst_req_cmd", req_cmd_in, 0);
    chk("async_rst_req_data", req_data_in, 0);
    chk("async_rst_outstanding", outstanding, 0);
    chk("async_rst_op_ready", op_ready, 0);
    model_reset();
    out_resp = '0;
    @(posedge c_clk);
    @(posedge c_clk);
    #1;
    reset = 1;
    tick();
    op_valid = 1; op_cmd = CMD_SUB; op_data1 = 32'd10; op_data2 = 32'd4;
    tick();
    op_valid = 0;
    drain();

    // Randomized traffic.
    dly_mode = 0;
    for (int k = 0; k < 300; k++) begin
      op_valid  = ($urandom_range(0, 1) == 1);
      op_cmd    = 4'($urandom_range(0, 15));
      op_data1  = $urandom;
      op_data2  = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
